// File: rtl/riscv_id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// riscv_id_ex_stage_pkg
// Shared definitions for the ID/EX stage: the 4-bit ALU control codes driven
// into riscv_alu, the 2-bit alu_op encodings coming from decode, and the
// alu_op/funct -> ALU control decode function used at capture time.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_id_ex_stage_pkg;

   // ALU control codes understood by riscv_alu
   localparam logic [3:0] ALU_AND  = 4'h0;
   localparam logic [3:0] ALU_OR   = 4'h1;
   localparam logic [3:0] ALU_ADD  = 4'h2;
   localparam logic [3:0] ALU_SLL  = 4'h3;
   localparam logic [3:0] ALU_SRL  = 4'h4;
   localparam logic [3:0] ALU_SUB  = 4'h6;
   localparam logic [3:0] ALU_NONE = 4'hF;

   // alu_op encodings from the main decoder
   localparam logic [1:0] ALU_OP_MEM    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_ARITH  = 2'b10;
   localparam logic [1:0] ALU_OP_RSVD   = 2'b11;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       illegal;
   } alu_dec_t;

   // funct7_5 only distinguishes SUB from ADD for register-register forms;
   // for ADDI the same bit is an immediate bit and must not select SUB.
   function automatic alu_dec_t alu_decode(input logic [1:0] op,
                                           input logic [2:0] funct3,
                                           input logic       funct7_5,
                                           input logic       alu_src);
      alu_dec_t d;
      d.ctrl    = ALU_NONE;
      d.illegal = 1'b1;
      case (op)
         ALU_OP_MEM: begin
            d.ctrl    = ALU_ADD;
            d.illegal = 1'b0;
         end
         ALU_OP_BRANCH: begin
            d.ctrl    = ALU_SUB;
            d.illegal = 1'b0;
         end
         ALU_OP_ARITH: begin
            d.illegal = 1'b0;
            case (funct3)
               3'b000:  d.ctrl = (funct7_5 && !alu_src) ? ALU_SUB : ALU_ADD;
               3'b111:  d.ctrl = ALU_AND;
               3'b110:  d.ctrl = ALU_OR;
               3'b001:  d.ctrl = ALU_SLL;
               3'b101: begin
                  if (!funct7_5) begin
                     d.ctrl = ALU_SRL;
                  end else begin
                     d.illegal = 1'b1;
                  end
               end
               default: d.illegal = 1'b1;
            endcase
         end
         ALU_OP_RSVD: begin
            d.ctrl    = ALU_NONE;
            d.illegal = 1'b1;
         end
         default: begin
            d.ctrl    = ALU_NONE;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/riscv_fwd_mux.sv
// ---------------------------------------------------------------------------
// riscv_fwd_mux
// Operand forwarding select for one source register.
//   rs_i           register index being read
//   rf_data_i      value captured from the register file
//   mem_*_i        EX/MEM producer (write enable, rd, result)
//   wb_*_i         MEM/WB producer (write enable, rd, result)
//   fwd_data_o     newest architectural value of rs_i
// ---------------------------------------------------------------------------
module riscv_fwd_mux #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs_i,
   input  logic [XLEN-1:0]   rf_data_i,
   input  logic              mem_reg_write_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic [XLEN-1:0]   mem_result_i,
   input  logic              wb_reg_write_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_result_i,
   output logic [XLEN-1:0]   fwd_data_o
);

   // x0 is hardwired zero, so a producer targeting it is never forwarded;
   // the younger EX/MEM result wins over MEM/WB.
   always_comb begin
      fwd_data_o = rf_data_i;
      if (rs_i != '0) begin
         if (mem_reg_write_i && (mem_rd_i == rs_i)) begin
            fwd_data_o = mem_result_i;
         end else if (wb_reg_write_i && (wb_rd_i == rs_i)) begin
            fwd_data_o = wb_result_i;
         end
      end
   end

endmodule

// File: rtl/riscv_id_ex_stage.sv
// ---------------------------------------------------------------------------
// riscv_id_ex_stage
// ID/EX pipeline register feeding riscv_alu. Captures decoded operands and
// control, registers the ALU control code, forwards from EX/MEM and MEM/WB,
// detects load-use hazards and handles stall (valid/ready) and flush.
//   clk_i, rstn_i               clock, async active-low reset
//   id_*                        instruction from decode, id_valid_i/id_ready_o
//   mem_*, wb_*                 forwarding sources
//   flush_i                     kill held and incoming instruction
//   ex_valid_o / ex_ready_i     handshake toward EX/MEM
//   alu_control_o, alu_a_o, alu_b_o   straight into riscv_alu
//   ex_store_data_o             forwarded rs2 for stores
//   ex_pc_o, ex_rd_o, ex_*_o    passthrough control, ex_illegal_o
// ---------------------------------------------------------------------------
module riscv_id_ex_stage
   import riscv_id_ex_stage_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              id_valid_i,
   output logic              id_ready_o,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic [1:0]        id_alu_op_i,
   input  logic [2:0]        id_funct3_i,
   input  logic              id_funct7_5_i,
   input  logic              id_alu_src_i,
   input  logic              id_mem_read_i,
   input  logic              id_mem_write_i,
   input  logic              id_reg_write_i,
   input  logic              id_branch_i,
   input  logic              mem_reg_write_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic [XLEN-1:0]   mem_result_i,
   input  logic              wb_reg_write_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_result_i,
   input  logic              flush_i,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output logic [3:0]        alu_control_o,
   output logic [XLEN-1:0]   alu_a_o,
   output logic [XLEN-1:0]   alu_b_o,
   output logic [XLEN-1:0]   ex_store_data_o,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              ex_mem_read_o,
   output logic              ex_mem_write_o,
   output logic              ex_reg_write_o,
   output logic              ex_branch_o,
   output logic              ex_illegal_o
);

   logic              vld_p1;
   logic [XLEN-1:0]   pc_p1;
   logic [XLEN-1:0]   rs1_data_p1;
   logic [XLEN-1:0]   rs2_data_p1;
   logic [XLEN-1:0]   imm_p1;
   logic [REG_AW-1:0] rs1_p1;
   logic [REG_AW-1:0] rs2_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [3:0]        alu_ctrl_p1;
   logic              illegal_p1;
   logic              alu_src_p1;
   logic              mem_read_p1;
   logic              mem_write_p1;
   logic              reg_write_p1;
   logic              branch_p1;

   logic [XLEN-1:0]   rs1_fwd;
   logic [XLEN-1:0]   rs2_fwd;
   logic              load_use;
   logic              accept;
   logic              stall;
   alu_dec_t          dec_p0;

   // ---- ID side (p0): hazard detection, handshake, ALU decode ----
   // rs2 is compared even for I-type instructions; a spurious bubble is
   // cheaper than decoding operand usage here.
   assign load_use = vld_p1 & mem_read_p1 & (rd_p1 != '0) &
                     ((rd_p1 == id_rs1_i) | (rd_p1 == id_rs2_i));

   // Ready is forced during flush so decode drops its instruction too.
   assign id_ready_o = flush_i | ((~vld_p1 | ex_ready_i) & ~load_use);
   assign accept     = id_valid_i & id_ready_o & ~flush_i;
   assign stall      = vld_p1 & ~ex_ready_i;
   assign dec_p0     = alu_decode(id_alu_op_i, id_funct3_i, id_funct7_5_i, id_alu_src_i);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_p1 <= 1'b0;
      end else if (flush_i) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
      end else if (ex_ready_i) begin
         vld_p1 <= 1'b0;
      end
   end

   // ---- ID/EX register (p1) ----
   // While stalled the forwarded values are written back so a producer that
   // retires out of MEM/WB during the stall is not lost.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pc_p1        <= '0;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         imm_p1       <= '0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         rd_p1        <= '0;
         alu_ctrl_p1  <= ALU_NONE;
         illegal_p1   <= 1'b0;
         alu_src_p1   <= 1'b0;
         mem_read_p1  <= 1'b0;
         mem_write_p1 <= 1'b0;
         reg_write_p1 <= 1'b0;
         branch_p1    <= 1'b0;
      end else if (accept) begin
         pc_p1        <= id_pc_i;
         rs1_data_p1  <= id_rs1_data_i;
         rs2_data_p1  <= id_rs2_data_i;
         imm_p1       <= id_imm_i;
         rs1_p1       <= id_rs1_i;
         rs2_p1       <= id_rs2_i;
         rd_p1        <= id_rd_i;
         alu_ctrl_p1  <= dec_p0.ctrl;
         illegal_p1   <= dec_p0.illegal;
         alu_src_p1   <= id_alu_src_i;
         mem_read_p1  <= id_mem_read_i;
         mem_write_p1 <= id_mem_write_i;
         reg_write_p1 <= id_reg_write_i;
         branch_p1    <= id_branch_i;
      end else if (stall) begin
         rs1_data_p1  <= rs1_fwd;
         rs2_data_p1  <= rs2_fwd;
      end
   end

   // ---- EX side (p1): forwarding and ALU operand select ----
   riscv_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .rs_i            (rs1_p1),
      .rf_data_i       (rs1_data_p1),
      .mem_reg_write_i (mem_reg_write_i),
      .mem_rd_i        (mem_rd_i),
      .mem_result_i    (mem_result_i),
      .wb_reg_write_i  (wb_reg_write_i),
      .wb_rd_i         (wb_rd_i),
      .wb_result_i     (wb_result_i),
      .fwd_data_o      (rs1_fwd)
   );

   riscv_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .rs_i            (rs2_p1),
      .rf_data_i       (rs2_data_p1),
      .mem_reg_write_i (mem_reg_write_i),
      .mem_rd_i        (mem_rd_i),
      .mem_result_i    (mem_result_i),
      .wb_reg_write_i  (wb_reg_write_i),
      .wb_rd_i         (wb_rd_i),
      .wb_result_i     (wb_result_i),
      .fwd_data_o      (rs2_fwd)
   );

   assign ex_valid_o      = vld_p1;
   assign alu_control_o   = alu_ctrl_p1;
   assign alu_a_o         = rs1_fwd;
   assign alu_b_o         = alu_src_p1 ? imm_p1 : rs2_fwd;
   assign ex_store_data_o = rs2_fwd;
   assign ex_pc_o         = pc_p1;
   assign ex_rd_o         = rd_p1;
   assign ex_mem_read_o   = mem_read_p1;
   assign ex_mem_write_o  = mem_write_p1;
   assign ex_reg_write_o  = reg_write_p1;
   assign ex_branch_o     = branch_p1;
   assign ex_illegal_o    = illegal_p1;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
module tb_riscv_id_ex_stage;
   import riscv_id_ex_stage_pkg::*;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        id_valid_i;
   logic        id_ready_o;
   logic [63:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic [1:0]  id_alu_op_i;
   logic [2:0]  id_funct3_i;
   logic        id_funct7_5_i, id_alu_src_i;
   logic        id_mem_read_i, id_mem_write_i, id_reg_write_i, id_branch_i;
   logic        mem_reg_write_i;
   logic [4:0]  mem_rd_i;
   logic [63:0] mem_result_i;
   logic        wb_reg_write_i;
   logic [4:0]  wb_rd_i;
   logic [63:0] wb_result_i;
   logic        flush_i;
   logic        ex_valid_o;
   logic        ex_ready_i;
   logic [3:0]  alu_control_o;
   logic [63:0] alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o;
   logic [4:0]  ex_rd_o;
   logic        ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_illegal_o;

   always #5 clk_i = ~clk_i;

   riscv_id_ex_stage #(.XLEN(64), .REG_AW(5)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
      .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
      .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .id_alu_op_i(id_alu_op_i), .id_funct3_i(id_funct3_i), .id_funct7_5_i(id_funct7_5_i),
      .id_alu_src_i(id_alu_src_i), .id_mem_read_i(id_mem_read_i),
      .id_mem_write_i(id_mem_write_i), .id_reg_write_i(id_reg_write_i),
      .id_branch_i(id_branch_i),
      .mem_reg_write_i(mem_reg_write_i), .mem_rd_i(mem_rd_i), .mem_result_i(mem_result_i),
      .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
      .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .alu_control_o(alu_control_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o),
      .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
      .ex_reg_write_o(ex_reg_write_o), .ex_branch_o(ex_branch_o),
      .ex_illegal_o(ex_illegal_o)
   );

   typedef struct {
      logic [63:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f75, src, mr, mw, rw, br;
   } id_t;

   typedef struct {
      logic [3:0]  ctrl;
      logic        ill;
      logic [63:0] a, b, sd, pc;
      logic [4:0]  rd;
      logic        mr, mw, rw, br;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic id_t mk_id(input logic [63:0] pc, input logic [1:0] op, input logic [2:0] f3,
                                 input logic f75, input logic src,
                                 input logic [4:0] rs1, input logic [63:0] rs1d,
                                 input logic [4:0] rs2, input logic [63:0] rs2d,
                                 input logic [63:0] imm, input logic [4:0] rd,
                                 input logic mr, input logic mw, input logic rw, input logic br);
      id_t d;
      d.pc = pc; d.op = op; d.f3 = f3; d.f75 = f75; d.src = src;
      d.rs1 = rs1; d.rs1d = rs1d; d.rs2 = rs2; d.rs2d = rs2d; d.imm = imm; d.rd = rd;
      d.mr = mr; d.mw = mw; d.rw = rw; d.br = br;
      return d;
   endfunction

   function automatic exp_t mk_exp(input logic [3:0] ctrl, input logic ill,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] sd, input logic [63:0] pc,
                                   input logic [4:0] rd, input logic mr, input logic mw,
                                   input logic rw, input logic br);
      exp_t e;
      e.ctrl = ctrl; e.ill = ill; e.a = a; e.b = b; e.sd = sd; e.pc = pc; e.rd = rd;
      e.mr = mr; e.mw = mw; e.rw = rw; e.br = br;
      return e;
   endfunction

   task automatic drive_id(input id_t d);
      id_pc_i = d.pc; id_rs1_data_i = d.rs1d; id_rs2_data_i = d.rs2d; id_imm_i = d.imm;
      id_rs1_i = d.rs1; id_rs2_i = d.rs2; id_rd_i = d.rd;
      id_alu_op_i = d.op; id_funct3_i = d.f3; id_funct7_5_i = d.f75; id_alu_src_i = d.src;
      id_mem_read_i = d.mr; id_mem_write_i = d.mw; id_reg_write_i = d.rw; id_branch_i = d.br;
   endtask

   // Present one instruction, wait for acceptance, push its expectation at the
   // capture edge; returns just after the negedge following capture.
   task automatic issue(input id_t d, input exp_t e, input bit push);
      int n;
      @(posedge clk_i); #1;
      drive_id(d);
      id_valid_i = 1'b1;
      n = 0;
      #1;
      while (!id_ready_o && n < 20) begin
         @(posedge clk_i); #2;
         n++;
      end
      if (n >= 20) begin
         tests++; fails++;
         $display("FAIL issue_timeout: got id_ready_o=0 for 20 cycles expected 1");
      end
      @(posedge clk_i);
      if (push) q.push_back(e);
      #1;
      id_valid_i = 1'b0;
      chk("capture_valid", 64'(ex_valid_o), 64'd1);
      @(negedge clk_i); #1;
   endtask

   task automatic idle_cycle();
      @(posedge clk_i); #1;
   endtask

   // Scoreboard monitor: every handshake out of EX consumes one expectation.
   always @(negedge clk_i) begin
      if (rstn_i === 1'b1 && ex_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out: got instruction pc %h expected none", ex_pc_o);
         end else begin
            mon_e = q.pop_front();
            chk("alu_control", 64'(alu_control_o), 64'(mon_e.ctrl));
            chk("illegal", 64'(ex_illegal_o), 64'(mon_e.ill));
            chk("alu_a", alu_a_o, mon_e.a);
            chk("alu_b", alu_b_o, mon_e.b);
            chk("store_data", ex_store_data_o, mon_e.sd);
            chk("pc", ex_pc_o, mon_e.pc);
            chk("rd", 64'(ex_rd_o), 64'(mon_e.rd));
            chk("ctl_bits", 64'({ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o}),
                64'({mon_e.mr, mon_e.mw, mon_e.rw, mon_e.br}));
         end
      end
   end

   id_t  d;
   exp_t e;

   initial begin
      rstn_i = 1'b0; id_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
      d = mk_id(64'd0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 5'd0,
                1'b0, 1'b0, 1'b0, 1'b0);
      drive_id(d);
      mem_reg_write_i = 1'b0; mem_rd_i = 5'd0; mem_result_i = 64'd0;
      wb_reg_write_i = 1'b0; wb_rd_i = 5'd0; wb_result_i = 64'd0;
      #12;
      chk("rst_valid", 64'(ex_valid_o), 64'd0);
      chk("rst_ctrl", 64'(alu_control_o), 64'(ALU_NONE));
      chk("rst_a", alu_a_o, 64'd0);
      chk("rst_b", alu_b_o, 64'd0);
      chk("rst_ctl", 64'({ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_illegal_o}), 64'd0);
      chk("rst_ready", 64'(id_ready_o), 64'd1);
      #1 rstn_i = 1'b1;

      // ALU decode sweep
      issue(mk_id(64'h100, 2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 64'd5, 5'd2, 64'd3, 64'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_SUB, 1'b0, 64'd5, 64'd3, 64'd3, 64'h100, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h104, 2'b10, 3'b000, 1'b1, 1'b1, 5'd1, 64'd10, 5'd2, 64'h77, 64'hFFFF_FFFF_FFFF_FFFC, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 64'h104, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h108, 2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 64'hF0F0, 5'd2, 64'hFF00, 64'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_AND, 1'b0, 64'hF0F0, 64'hFF00, 64'hFF00, 64'h108, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h10C, 2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 64'h1, 5'd2, 64'h2, 64'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_OR, 1'b0, 64'h1, 64'h2, 64'h2, 64'h10C, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h110, 2'b10, 3'b001, 1'b0, 1'b1, 5'd1, 64'h8, 5'd2, 64'h9, 64'd3, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_SLL, 1'b0, 64'h8, 64'd3, 64'h9, 64'h110, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h114, 2'b10, 3'b101, 1'b0, 1'b0, 5'd1, 64'h80, 5'd2, 64'h4, 64'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_SRL, 1'b0, 64'h80, 64'h4, 64'h4, 64'h114, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h118, 2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 64'h2000, 5'd2, 64'hDEAD, 64'h10, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'h2000, 64'h10, 64'hDEAD, 64'h118, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
      issue(mk_id(64'h11C, 2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 64'h30, 5'd2, 64'h30, 64'h40, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1),
            mk_exp(ALU_SUB, 1'b0, 64'h30, 64'h30, 64'h30, 64'h11C, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
      issue(mk_id(64'h120, 2'b10, 3'b010, 1'b0, 1'b0, 5'd1, 64'h5, 5'd2, 64'h6, 64'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_NONE, 1'b1, 64'h5, 64'h6, 64'h6, 64'h120, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h124, 2'b11, 3'b000, 1'b0, 1'b0, 5'd1, 64'h5, 5'd2, 64'h6, 64'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_NONE, 1'b1, 64'h5, 64'h6, 64'h6, 64'h124, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h128, 2'b10, 3'b101, 1'b1, 1'b0, 5'd1, 64'h5, 5'd2, 64'h6, 64'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_NONE, 1'b1, 64'h5, 64'h6, 64'h6, 64'h128, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);

      // Forwarding priority
      mem_reg_write_i = 1'b1; mem_rd_i = 5'd7; mem_result_i = 64'hAA;
      wb_reg_write_i = 1'b1; wb_rd_i = 5'd7; wb_result_i = 64'hBB;
      issue(mk_id(64'h130, 2'b10, 3'b000, 1'b0, 1'b0, 5'd7, 64'h11, 5'd2, 64'h22, 64'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'hAA, 64'h22, 64'h22, 64'h130, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      mem_reg_write_i = 1'b0;
      issue(mk_id(64'h134, 2'b10, 3'b000, 1'b0, 1'b0, 5'd7, 64'h11, 5'd2, 64'h22, 64'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'hBB, 64'h22, 64'h22, 64'h134, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      mem_reg_write_i = 1'b1; mem_rd_i = 5'd0; wb_rd_i = 5'd0;
      issue(mk_id(64'h138, 2'b10, 3'b000, 1'b0, 1'b0, 5'd0, 64'h33, 5'd0, 64'h44, 64'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'h33, 64'h44, 64'h44, 64'h138, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      mem_rd_i = 5'd9; wb_rd_i = 5'd9;
      issue(mk_id(64'h13C, 2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 64'h1, 5'd9, 64'h99, 64'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'h1, 64'hAA, 64'hAA, 64'h13C, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      issue(mk_id(64'h140, 2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 64'h1, 5'd9, 64'h99, 64'h10, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'h1, 64'h10, 64'hAA, 64'h140, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
      mem_reg_write_i = 1'b0; wb_reg_write_i = 1'b0;

      // Load-use: lw x4 in EX, add using x4 in ID
      issue(mk_id(64'h200, 2'b00, 3'b010, 1'b0, 1'b1, 5'd1, 64'h1000, 5'd2, 64'h5, 64'd8, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'h1000, 64'd8, 64'h5, 64'h200, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
      drive_id(mk_id(64'h204, 2'b10, 3'b000, 1'b0, 1'b0, 5'd4, 64'h66, 5'd2, 64'h5, 64'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0));
      id_valid_i = 1'b1;
      #1 chk("load_use_ready", 64'(id_ready_o), 64'd0);
      @(posedge clk_i); #1;
      chk("load_use_bubble", 64'(ex_valid_o), 64'd0);
      chk("load_use_release", 64'(id_ready_o), 64'd1);
      q.push_back(mk_exp(ALU_ADD, 1'b0, 64'h66, 64'h5, 64'h5, 64'h204, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0));
      @(posedge clk_i); #1;
      id_valid_i = 1'b0;
      chk("load_use_accept", 64'(ex_valid_o), 64'd1);
      @(negedge clk_i); #1;
      idle_cycle();

      // Stall refresh: MEM forwards rs2 only before the first stalled edge
      mem_reg_write_i = 1'b1; mem_rd_i = 5'd3; mem_result_i = 64'h1234;
      ex_ready_i = 1'b0;
      issue(mk_id(64'h300, 2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 64'd9, 5'd3, 64'h55, 64'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'd9, 64'h1234, 64'h1234, 64'h300, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      chk("stall_c1_b", alu_b_o, 64'h1234);
      @(posedge clk_i); #1;
      mem_reg_write_i = 1'b0;
      chk("stall_c2_b", alu_b_o, 64'h1234);
      chk("stall_c2_valid", 64'(ex_valid_o), 64'd1);
      @(posedge clk_i); #1;
      chk("stall_c3_b", alu_b_o, 64'h1234);
      chk("stall_c3_sd", ex_store_data_o, 64'h1234);
      ex_ready_i = 1'b1;
      @(negedge clk_i); #1;
      idle_cycle();

      // Flush during stall with an incoming instruction
      ex_ready_i = 1'b0;
      issue(mk_id(64'h400, 2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 64'd1, 5'd2, 64'd2, 64'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_ADD, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      drive_id(mk_id(64'h500, 2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 64'd1, 5'd2, 64'd2, 64'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0));
      id_valid_i = 1'b1; flush_i = 1'b1;
      #1 chk("flush_ready", 64'(id_ready_o), 64'd1);
      @(posedge clk_i); #1;
      flush_i = 1'b0; id_valid_i = 1'b0;
      chk("flush_kill", 64'(ex_valid_o), 64'd0);
      @(posedge clk_i); #1;
      chk("flush_no_capture", 64'(ex_valid_o), 64'd0);
      chk("flush_pc_hold", ex_pc_o, 64'h400);
      ex_ready_i = 1'b1;
      idle_cycle();

      // Async reset while an illegal instruction is stalled in EX
      ex_ready_i = 1'b0;
      issue(mk_id(64'h600, 2'b11, 3'b000, 1'b0, 1'b1, 5'd1, 64'd7, 5'd2, 64'd8, 64'h20, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0),
            mk_exp(ALU_NONE, 1'b1, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      #1 rstn_i = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ex_valid_o), 64'd0);
      chk("mid_rst_ctrl", 64'(alu_control_o), 64'(ALU_NONE));
      chk("mid_rst_illegal", 64'(ex_illegal_o), 64'd0);
      chk("mid_rst_a", alu_a_o, 64'd0);
      chk("mid_rst_b", alu_b_o, 64'd0);
      chk("mid_rst_pc", ex_pc_o, 64'd0);
      chk("mid_rst_ctl", 64'({ex_mem_read_o, ex_reg_write_o}), 64'd0);
      rstn_i = 1'b1;
      ex_ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("no_replay", 64'(ex_valid_o), 64'd0);

      repeat (2) @(posedge clk_i);
      #1 chk("queue_drain", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/riscv_id_ex_stage.md
Name: riscv_id_ex_stage

Overview:
ID/EX pipeline stage directly upstream of riscv_alu. It registers decoded operands and control from decode, generates the 4-bit ALU control code from alu_op/funct fields, and resolves EX/MEM and MEM/WB forwarding. It drives alu_control/alu_a/alu_b straight into the ALU, detects load-use hazards, and supports stall (valid/ready) and flush.

Parameters:
XLEN, 64, datapath width (must match the ALU's 64-bit operands)
REG_AW, 5, register index width

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
id_valid_i  in  1  decode holds a valid instruction
id_ready_o  out  1  stage accepts the instruction this cycle
id_pc_i  in  XLEN  instruction PC
id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data
id_imm_i  in  XLEN  sign-extended immediate
id_rs1_i / id_rs2_i / id_rd_i  in  REG_AW  register indices
id_alu_op_i  in  2  00 mem, 01 branch, 10 R/I arith, 11 reserved
id_funct3_i  in  3  funct3
id_funct7_5_i  in  1  instr[30]
id_alu_src_i  in  1  1 = operand B is immediate
id_mem_read_i / id_mem_write_i / id_reg_write_i / id_branch_i  in  1  control bits
mem_reg_write_i, mem_rd_i, mem_result_i  in  1/REG_AW/XLEN  EX/MEM forwarding source
wb_reg_write_i, wb_rd_i, wb_result_i  in  1/REG_AW/XLEN  MEM/WB forwarding source
flush_i  in  1  kill held and incoming instruction
ex_valid_o  out  1  EX slot holds a valid instruction
ex_ready_i  in  1  downstream (EX/MEM) accepts
alu_control_o  out  4  to riscv_alu alu_control_i
alu_a_o / alu_b_o  out  XLEN  to riscv_alu alu_a_i / alu_b_i
ex_store_data_o  out  XLEN  forwarded rs2 value for stores
ex_pc_o, ex_rd_o  out  XLEN/REG_AW  passthrough
ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_illegal_o  out  1  passthrough control / illegal ALU op

Behaviour:
- Reset (rstn_i low, async): ex_valid_o=0, all data regs 0, alu_control_o=`ALU_NONE, all control outs 0.
- Load-use: load_use = ex_valid_o & ex_mem_read_o & ex_rd_o!=0 & (ex_rd_o==id_rs1_i | ex_rd_o==id_rs2_i) (conservative rs2 compare).
- id_ready_o = flush_i | ((!ex_valid_o | ex_ready_i) & !load_use).
- Per clock, priority order: flush_i -> ex_valid_o<=0, incoming dropped; else accept (id_valid_i & id_ready_o) -> capture all id_* fields, ex_valid_o<=1; else if ex_ready_i -> ex_valid_o<=0 (bubble, incl. load-use); else hold.
- Latency: 1 cycle ID capture to ALU inputs; throughput 1/cycle with ex_ready_i=1.
- ALU control, decoded at capture and registered: op 00 -> ADD; 01 -> SUB; 10 by funct3: 000 ADD (SUB when funct7_5=1 & alu_src=0), 111 AND, 110 OR, 001 SLL, 101 SRL when funct7_5=0; any other funct3/funct7_5, or op 11 -> `ALU_NONE with ex_illegal_o=1.
- Forwarding (combinational on held rs values): MEM match (mem_reg_write_i & mem_rd_i!=0 & mem_rd_i==rs) beats WB match; x0 never forwarded; no match -> registered RF data.
- alu_a_o = fwd(rs1); alu_b_o = alu_src ? imm : fwd(rs2); ex_store_data_o = fwd(rs2) always.
- Stall refresh: while ex_valid_o & !ex_ready_i, every cycle write the forwarded rs1/rs2 values back into the held operand regs, so values survive the producer leaving MEM/WB.
- Outputs are meaningful only when ex_valid_o=1; they hold value across bubbles.
- Reset mid-stall clears the slot; no instruction replays.

Decomposition:
- Add `ALU_NONE (4'hF) and the ALU_OP_* 2-bit encodings to riscv_defs.v next to the existing ALU_* codes.
- One sub-module: riscv_fwd_mux (rs index + RF data + two sources -> XLEN value), instantiated twice.

Test Plan:
- R-type sub: alu_op=10, funct3=000, funct7_5=1, alu_src=0, rs1=5, rs2=3 -> next cycle alu_control_o=`ALU_SUB, alu_a_o=5, alu_b_o=3, ex_valid_o=1.
- Forward priority: rs1=x7, mem_rd=7 result 0xAA, wb_rd=7 result 0xBB -> alu_a_o=0xAA; set mem_reg_write_i=0 -> 0xBB; rs1=x0 with both matching on x0 -> RF data.
- Load-use: EX holds lw x4, ID has add using x4 -> id_ready_o=0 one cycle, ex_valid_o=0 next cycle (bubble), add accepted the cycle after.
- Stall refresh: ex_ready_i=0 for 3 cycles, forwarded rs2=0x1234 from MEM in cycle 1 only -> alu_b_o stays 0x1234 through cycle 3.
- Flush during stall with id_valid_i=1 -> ex_valid_o=0 next cycle, incoming not captured.
- Illegal: alu_op=10, funct3=010 -> alu_control_o=`ALU_NONE, ex_illegal_o=1; async reset mid-stall -> all outputs reset values immediately.
